// File: rtl/loop_mixer_n_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : loop_mixer_n_if
//  Description : Sample return, mix request and PWM result bundle for the
//                N-channel loop mixer.
//  Revision    : 1.0  initial release
// ============================================================================
interface loop_mixer_n_if #(
    parameter int NCH = 8,
    parameter int DW  = 16,
    parameter int AW  = 3,
    parameter int OW  = 11
);
    logic                     smp_valid;
    logic [$clog2(NCH)-1:0]   smp_bank;
    logic [DW-1:0]            smp_data;
    logic [NCH-1:0]           playing;
    logic [NCH*AW-1:0]        atten;
    logic [DW-1:0]            aux_data;
    logic                     aux_en;
    logic                     mix_start;
    logic                     busy;
    logic                     mix_done;
    logic                     clip;
    logic [OW-1:0]            pwm_code;

    modport master (
        output smp_valid, smp_bank, smp_data, playing, atten,
        output aux_data, aux_en, mix_start,
        input  busy, mix_done, clip, pwm_code
    );

    modport slave (
        input  smp_valid, smp_bank, smp_data, playing, atten,
        input  aux_data, aux_en, mix_start,
        output busy, mix_done, clip, pwm_code
    );
endinterface
`default_nettype wire

// File: rtl/loop_mixer_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : loop_mixer_n
//  Description : N-channel loop mixer: per-bank sample latch, serial
//                attenuate-and-accumulate, saturation with clip flag and a
//                registered PWM duty code. Optional LFSR dither before
//                truncation is enabled by defining LOOP_MIXER_DITHER_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module loop_mixer_n #(
    parameter int NCH = 8,
    parameter int DW  = 16,
    parameter int AW  = 3,
    parameter int OW  = 11
) (
    input  logic           clk_100MHz,
    input  logic           rst,
    loop_mixer_n_if.slave  bus
);
    localparam int IW   = $clog2(NCH);
    localparam int ACCW = DW + $clog2(NCH + 1) + 1;
`ifdef LOOP_MIXER_DITHER_EN
    localparam int c_KW = DW;
`else
    localparam int c_KW = OW;
`endif

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_acc  = 2'd1;
    localparam logic [1:0] c_st_sat  = 2'd2;
    localparam logic [1:0] c_st_out  = 2'd3;

    localparam logic signed [ACCW-1:0] c_sat_hi = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] c_sat_lo = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [OW-1:0]          c_pwm_mid = {1'b1, {(OW-1){1'b0}}};

    logic signed [DW-1:0]   r_ch [NCH];
    logic [1:0]             r_state;
    logic signed [ACCW-1:0] r_acc;
    logic [IW-1:0]          r_idx;
    logic [c_KW-1:0]        r_u;
    logic                   r_clip_n;
    logic                   r_busy;
    logic                   r_mix_done;
    logic                   r_clip;
    logic [OW-1:0]          r_pwm_code;

    // Offset binary to two's complement is a flip of the MSB.
    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_ch
            always_ff @(posedge clk_100MHz or posedge rst) begin
                if (rst) begin
                    r_ch[k] <= '0;
                end else if (!bus.playing[k]) begin
                    r_ch[k] <= '0;
                end else if (bus.smp_valid && (bus.smp_bank == IW'(k))) begin
                    r_ch[k] <= {~bus.smp_data[DW-1], bus.smp_data[DW-2:0]};
                end
            end
        end
    endgenerate

    logic signed [DW-1:0]   w_ch_sel;
    logic [AW-1:0]          w_shift;
    logic signed [ACCW-1:0] w_ch_ext;
    logic signed [ACCW-1:0] w_term;
    logic signed [ACCW-1:0] w_aux_ext;
    logic                   w_over;
    logic                   w_under;
    logic [c_KW-1:0]        w_u_keep;
    logic [OW-1:0]          w_pwm_next;

    assign w_ch_sel  = r_ch[r_idx];
    assign w_shift   = bus.atten[r_idx*AW +: AW];
    assign w_ch_ext  = $signed({{(ACCW-DW){w_ch_sel[DW-1]}}, w_ch_sel});
    assign w_term    = w_ch_ext >>> w_shift;
    assign w_aux_ext = $signed({{(ACCW-DW+1){~bus.aux_data[DW-1]}}, bus.aux_data[DW-2:0]});

    // Clamp and return to offset binary in one step: the rails map to all-ones/all-zeros.
    assign w_over   = (r_acc > c_sat_hi);
    assign w_under  = (r_acc < c_sat_lo);
    assign w_u_keep = w_over  ? {c_KW{1'b1}} :
                      w_under ? {c_KW{1'b0}} :
                      {~r_acc[DW-1], r_acc[DW-2 -: c_KW-1]};

`ifdef LOOP_MIXER_DITHER_EN
    logic [15:0] r_lfsr;
    logic [DW:0] w_dsum;

    assign w_dsum     = {1'b0, r_u} + {{(OW+1){1'b0}}, r_lfsr[DW-OW-1:0]};
    assign w_pwm_next = w_dsum[DW] ? {OW{1'b1}} : w_dsum[DW-1 -: OW];

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else if (r_state == c_st_out) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end
`else
    assign w_pwm_next = r_u;
`endif

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_acc      <= '0;
            r_idx      <= '0;
            r_u        <= '0;
            r_clip_n   <= 1'b0;
            r_busy     <= 1'b0;
            r_mix_done <= 1'b0;
            r_clip     <= 1'b0;
            r_pwm_code <= c_pwm_mid;
        end else begin
            r_mix_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.mix_start) begin
                        r_acc   <= bus.aux_en ? w_aux_ext : '0;
                        r_idx   <= '0;
                        r_state <= c_st_acc;
                    end
                end
                c_st_acc: begin
                    r_busy <= 1'b1;
                    r_acc  <= r_acc + w_term;
                    if (r_idx == IW'(NCH - 1)) begin
                        r_state <= c_st_sat;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                c_st_sat: begin
                    r_u      <= w_u_keep;
                    r_clip_n <= w_over | w_under;
                    r_state  <= c_st_out;
                end
                c_st_out: begin
                    r_pwm_code <= w_pwm_next;
                    r_clip     <= r_clip_n;
                    r_mix_done <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.mix_done = r_mix_done;
    assign bus.clip     = r_clip;
    assign bus.pwm_code = r_pwm_code;

endmodule
`default_nettype wire

// File: tb/tb_loop_mixer_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_loop_mixer_n
//  Description : Directed self-checking bench for loop_mixer_n (NCH=8).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_loop_mixer_n;
    localparam int NCH = 8;
    localparam int DW  = 16;
    localparam int AW  = 3;
    localparam int OW  = 11;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    loop_mixer_n_if #(.NCH(NCH), .DW(DW), .AW(AW), .OW(OW)) bus ();

    loop_mixer_n #(.NCH(NCH), .DW(DW), .AW(AW), .OW(OW)) dut (
        .clk_100MHz (clk),
        .rst        (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic load_sample(input int bank, input logic [15:0] data);
        bus.smp_valid = 1'b1;
        bus.smp_bank  = 3'(bank);
        bus.smp_data  = data;
        @(negedge clk);
        bus.smp_valid = 1'b0;
    endtask

    // cyc = edge index of mix_done relative to the accepting edge, -1 on timeout.
    task automatic run_mix(output int cyc, output int nbusy);
        cyc   = -1;
        nbusy = 0;
        bus.mix_start = 1'b1;
        @(negedge clk);
        bus.mix_start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.mix_done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.smp_valid = 1'b0; bus.smp_bank = '0; bus.smp_data = '0;
        bus.playing = '0; bus.atten = '0; bus.aux_data = '0;
        bus.aux_en = 1'b0; bus.mix_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.pwm_code !== 11'd1024) begin failures++; $display("FAIL reset_pwm got %0d want 1024", bus.pwm_code); end
        checks++; if (bus.clip !== 1'b0) begin failures++; $display("FAIL reset_clip got %b want 0", bus.clip); end
        checks++; if (bus.mix_done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", bus.mix_done); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_mix;
        int cyc, nb;
        run_mix(cyc, nb);
        checks++; if (cyc !== 10) begin failures++; $display("FAIL idle_latency got %0d want 10", cyc); end
        checks++; if (nb !== 9) begin failures++; $display("FAIL idle_busy_cycles got %0d want 9", nb); end
        checks++; if (bus.pwm_code !== 11'd1024) begin failures++; $display("FAIL idle_pwm got %0d want 1024", bus.pwm_code); end
        checks++; if (bus.clip !== 1'b0) begin failures++; $display("FAIL idle_clip got %b want 0", bus.clip); end
        @(negedge clk);
        checks++; if (bus.mix_done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got %b want 0", bus.mix_done); end
    endtask

    task automatic test_gain;
        int cyc, nb;
        bus.playing = 8'h01; bus.atten = '0;
        load_sample(0, 16'hC000);
        run_mix(cyc, nb);
        checks++; if (bus.pwm_code !== 11'd1536) begin failures++; $display("FAIL gain_b0 got %0d want 1536", bus.pwm_code); end
        bus.playing = 8'h02; bus.atten = 24'h000010;
        load_sample(1, 16'hC000);
        run_mix(cyc, nb);
        checks++; if (bus.pwm_code !== 11'd1152) begin failures++; $display("FAIL gain_b1_pos got %0d want 1152", bus.pwm_code); end
        load_sample(1, 16'h4000);
        run_mix(cyc, nb);
        checks++; if (bus.pwm_code !== 11'd896) begin failures++; $display("FAIL gain_b1_neg got %0d want 896", bus.pwm_code); end
        checks++; if (bus.clip !== 1'b0) begin failures++; $display("FAIL gain_clip got %b want 0", bus.clip); end
    endtask

    task automatic test_saturation;
        int cyc, nb;
        bus.playing = 8'h0F; bus.atten = '0;
        for (int b = 0; b < 4; b++) load_sample(b, 16'hFFFF);
        run_mix(cyc, nb);
        checks++; if (bus.pwm_code !== 11'd2047) begin failures++; $display("FAIL sat_hi_pwm got %0d want 2047", bus.pwm_code); end
        checks++; if (bus.clip !== 1'b1) begin failures++; $display("FAIL sat_hi_clip got %b want 1", bus.clip); end
        for (int b = 0; b < 4; b++) load_sample(b, 16'h0000);
        run_mix(cyc, nb);
        checks++; if (bus.pwm_code !== 11'd0) begin failures++; $display("FAIL sat_lo_pwm got %0d want 0", bus.pwm_code); end
        checks++; if (bus.clip !== 1'b1) begin failures++; $display("FAIL sat_lo_clip got %b want 1", bus.clip); end
    endtask

    task automatic test_playing_gate;
        int cyc, nb;
        bus.playing = 8'h04;
        load_sample(2, 16'hC000);
        bus.playing = 8'h00;
        @(negedge clk);
        run_mix(cyc, nb);
        checks++; if (bus.pwm_code !== 11'd1024) begin failures++; $display("FAIL gate_off_pwm got %0d want 1024", bus.pwm_code); end
        checks++; if (bus.clip !== 1'b0) begin failures++; $display("FAIL gate_off_clip got %b want 0", bus.clip); end
        bus.playing = 8'h04;
        run_mix(cyc, nb);
        checks++; if (bus.pwm_code !== 11'd1024) begin failures++; $display("FAIL gate_cleared_pwm got %0d want 1024", bus.pwm_code); end
        bus.playing = 8'h00;
    endtask

    task automatic test_aux;
        int cyc, nb;
        bus.aux_en = 1'b1; bus.aux_data = 16'h0000;
        run_mix(cyc, nb);
        checks++; if (bus.pwm_code !== 11'd0) begin failures++; $display("FAIL aux_min_pwm got %0d want 0", bus.pwm_code); end
        checks++; if (bus.clip !== 1'b0) begin failures++; $display("FAIL aux_min_clip got %b want 0", bus.clip); end
        bus.aux_data = 16'hFFFF; bus.playing = 8'h01; bus.atten = '0;
        load_sample(0, 16'hC000);
        run_mix(cyc, nb);
        checks++; if (bus.pwm_code !== 11'd2047) begin failures++; $display("FAIL aux_sum_pwm got %0d want 2047", bus.pwm_code); end
        checks++; if (bus.clip !== 1'b1) begin failures++; $display("FAIL aux_sum_clip got %b want 1", bus.clip); end
        bus.aux_en = 1'b0; bus.playing = 8'h00;
        @(negedge clk);
    endtask

    // Extra request at edge 4 must be dropped; a request in the mix_done cycle must be taken.
    task automatic test_back_to_back;
        int ndone = 0;
        int first = -1;
        int second = -1;
        bus.mix_start = 1'b1;
        @(negedge clk);
        bus.mix_start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.mix_done) begin
                ndone++;
                if (first < 0) first = c; else if (second < 0) second = c;
            end
            bus.mix_start = (c == 3) || (c == 10);
        end
        bus.mix_start = 1'b0;
        checks++; if (ndone !== 2) begin failures++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
        checks++; if (first !== 10) begin failures++; $display("FAIL b2b_first got %0d want 10", first); end
        checks++; if (second !== 21) begin failures++; $display("FAIL b2b_second got %0d want 21", second); end
    endtask

    task automatic test_reset_mid_mix;
        int cyc, nb;
        int ndone = 0;
        bus.playing = 8'h01; bus.atten = '0;
        load_sample(0, 16'hC000);
        run_mix(cyc, nb);
        checks++; if (bus.pwm_code !== 11'd1536) begin failures++; $display("FAIL rstmid_pre_pwm got %0d want 1536", bus.pwm_code); end
        bus.mix_start = 1'b1;
        @(negedge clk);
        bus.mix_start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.pwm_code !== 11'd1024) begin failures++; $display("FAIL rstmid_pwm got %0d want 1024", bus.pwm_code); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.mix_done) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL rstmid_no_done got %0d want 0", ndone); end
    endtask

    initial begin
        test_reset();
        test_idle_mix();
        test_gain();
        test_saturation();
        test_playing_gate();
        test_aux();
        test_back_to_back();
        test_reset_mid_mix();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
